// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and defaults for the fetch-stage PC sequencer
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    BUBBLE = 2'd3
  } pcs_state_t;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect requests in, fetch PC and status out
interface pc_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            stall_i;
  logic            branch_i;
  logic            zero_i;
  logic [XLEN-1:0] branch_target_i;
  logic            jump_i;
  logic [XLEN-1:0] jump_target_i;
  logic            trap_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            redirect_o;
  logic            misaligned_o;
  logic            pend_o;

  modport master (
    output stall_i, branch_i, zero_i, branch_target_i, jump_i, jump_target_i, trap_i,
    input  pc_o, pc_valid_o, redirect_o, misaligned_o, pend_o
  );

  modport slave (
    input  stall_i, branch_i, zero_i, branch_target_i, jump_i, jump_target_i, trap_i,
    output pc_o, pc_valid_o, redirect_o, misaligned_o, pend_o
  );
endinterface

// File: rtl/pc_sequencer_src_mux.sv
// rtl/pc_sequencer_src_mux.sv - prioritised next-PC selector (trap > jump > taken branch > sequential)
module pc_src_mux
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic            i_trap,
  input  logic            i_jump,
  input  logic            i_branch,
  input  logic            i_zero,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_seq_pc,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_redirect,
  output logic            o_misaligned
);

  always_comb begin
    o_next_pc    = i_seq_pc;
    o_redirect   = 1'b0;
    o_misaligned = 1'b0;
    if (i_trap) begin
      o_next_pc  = TRAP_VEC;
      o_redirect = 1'b1;
    end else if (i_jump) begin
      o_redirect = 1'b1;
      if (is_misaligned(i_jump_target[1:0])) begin
        o_next_pc    = TRAP_VEC;
        o_misaligned = 1'b1;
      end else begin
        o_next_pc = i_jump_target;
      end
    end else if (i_branch && i_zero) begin
      o_redirect = 1'b1;
      if (is_misaligned(i_branch_target[1:0])) begin
        o_next_pc    = TRAP_VEC;
        o_misaligned = 1'b1;
      end else begin
        o_next_pc = i_branch_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered fetch PC with stall hold, pending redirect buffer and bubble insertion
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT,
  parameter int              PC_STEP  = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  pcs_state_t      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_redirect;
  logic            r_misaligned;
  logic            r_pend;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend_mis;

  pcs_state_t      w_state;
  logic [XLEN-1:0] w_pc;
  logic            w_pc_valid;
  logic            w_redirect;
  logic            w_misaligned;
  logic            w_pend;
  logic [XLEN-1:0] w_pend_pc;
  logic            w_pend_mis;

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_mux_pc;
  logic            w_mux_redirect;
  logic            w_mux_mis;

  assign w_seq_pc = r_pc + XLEN'(PC_STEP);

  pc_src_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_src_mux (
    .i_trap          (bus.trap_i),
    .i_jump          (bus.jump_i),
    .i_branch        (bus.branch_i),
    .i_zero          (bus.zero_i),
    .i_jump_target   (bus.jump_target_i),
    .i_branch_target (bus.branch_target_i),
    .i_seq_pc        (w_seq_pc),
    .o_next_pc       (w_mux_pc),
    .o_redirect      (w_mux_redirect),
    .o_misaligned    (w_mux_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_pc_valid   <= 1'b0;
      r_redirect   <= 1'b0;
      r_misaligned <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_mis   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_pc_valid   <= w_pc_valid;
      r_redirect   <= w_redirect;
      r_misaligned <= w_misaligned;
      r_pend       <= w_pend;
      r_pend_pc    <= w_pend_pc;
      r_pend_mis   <= w_pend_mis;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_pc_valid   = r_pc_valid;
    w_redirect   = 1'b0;
    w_misaligned = 1'b0;
    w_pend       = r_pend;
    w_pend_pc    = r_pend_pc;
    w_pend_mis   = r_pend_mis;

    // Trap overrides stall in every state and drops any buffered redirect.
    if (bus.trap_i) begin
      w_pc       = TRAP_VEC;
      w_pc_valid = 1'b0;
      w_redirect = 1'b1;
      w_pend     = 1'b0;
      w_pend_mis = 1'b0;
      w_state    = BUBBLE;
    end else begin
      unique case (r_state)
        BOOT: begin
          w_state = RUN;
        end
        RUN, BUBBLE: begin
          if (bus.stall_i) begin
            if (w_mux_redirect) begin
              w_pend     = 1'b1;
              w_pend_pc  = w_mux_pc;
              w_pend_mis = w_mux_mis;
              w_state    = HOLD;
            end
          end else if (w_mux_redirect) begin
            w_pc         = w_mux_pc;
            w_pc_valid   = 1'b0;
            w_redirect   = 1'b1;
            w_misaligned = w_mux_mis;
            w_state      = BUBBLE;
          end else begin
            w_pc       = w_seq_pc;
            w_pc_valid = 1'b1;
            w_state    = RUN;
          end
        end
        HOLD: begin
          if (bus.stall_i) begin
            if (w_mux_redirect) begin
              w_pend_pc  = w_mux_pc;
              w_pend_mis = w_mux_mis;
            end
          end else begin
            // A redirect arriving on the release cycle is newer than the buffer.
            if (w_mux_redirect) begin
              w_pc         = w_mux_pc;
              w_misaligned = w_mux_mis;
            end else begin
              w_pc         = r_pend_pc;
              w_misaligned = r_pend_mis;
            end
            w_pc_valid = 1'b0;
            w_redirect = 1'b1;
            w_pend     = 1'b0;
            w_pend_mis = 1'b0;
            w_state    = BUBBLE;
          end
        end
        default: begin
          w_state = BOOT;
        end
      endcase
    end
  end

  assign bus.pc_o         = r_pc;
  assign bus.pc_valid_o   = r_pc_valid;
  assign bus.redirect_o   = r_redirect;
  assign bus.misaligned_o = r_misaligned;
  assign bus.pend_o       = r_pend;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-PC selector and program-counter register. It generalises the datapath's 2:1 32-bit branch mux into a prioritised N-source selector with a registered PC, stall hold, pending-redirect buffering, bubble generation and misalignment trapping. It sits at the front of the fetch stage. It drives the instruction-memory address and the PC into the IF/ID pipeline register.

Parameters:
XLEN, 32, PC and target width in bits
RESET_PC, 0, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, redirect address for traps and misaligned targets
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold the current PC (downstream hazard)
branch_i  in  1  branch instruction resolved this cycle
zero_i  in  1  ALU zero flag for the branch
branch_target_i  in  XLEN  branch target address
jump_i  in  1  unconditional jump resolved this cycle
jump_target_i  in  XLEN  jump target address
trap_i  in  1  exception request
pc_o  out  XLEN  current fetch PC (registered)
pc_valid_o  out  1  pc_o is a real fetch; 0 means bubble
redirect_o  out  1  one-cycle pulse when the PC was redirected last edge
misaligned_o  out  1  one-cycle pulse when a target had bits [1:0] != 0
pend_o  out  1  a redirect is buffered behind a stall

Behaviour:
- Reset (async assert, sync-to-clk deassert is the caller's concern):
  - pc_o = RESET_PC, pc_valid_o = 0, redirect_o = 0, misaligned_o = 0, pend_o = 0.
  - state = BOOT; pending buffer cleared.
- Taken-branch condition is branch_i AND zero_i. It is not OR.
- Source priority per cycle, highest first:
  - trap_i → TRAP_VEC
  - jump_i → jump_target_i
  - taken branch → branch_target_i
  - otherwise pc_o + PC_STEP, wrapping modulo 2^XLEN; no overflow flag.
- Misalignment: a selected jump or branch target with [1:0] != 0 is replaced by TRAP_VEC, and misaligned_o pulses on that edge.
- States:
  - BOOT: one cycle after reset; pc_o stays RESET_PC, pc_valid_o rises on exit → RUN.
  - RUN, no stall, redirect selected: pc_o ← target; redirect_o = 1 and pc_valid_o = 0 for the following cycle → BUBBLE.
  - RUN, no stall, no redirect: pc_o ← pc_o + PC_STEP; pc_valid_o = 1.
  - RUN, stall_i = 1: pc_o and pc_valid_o hold. A jump or taken branch arriving during stall is captured in the pending buffer (target plus misaligned flag); pend_o = 1 → HOLD.
  - HOLD: pc_o holds. A newer jump or branch overwrites the buffer (last wins). When stall_i = 0, pc_o ← buffered target, redirect_o pulses, pend_o clears → BUBBLE.
  - BUBBLE: exactly one cycle with pc_valid_o = 0, then → RUN with pc_valid_o = 1.
  - A new redirect in BUBBLE is honoured immediately and stays in BUBBLE for one more cycle.
- Trap ignores stall_i in every state:
  - pc_o ← TRAP_VEC on the next edge.
  - The pending buffer is discarded, pend_o = 0.
  - → BUBBLE.
- Simultaneous events: trap beats jump beats branch; a redirect beats a stall only for trap.
- Reset asserted mid-operation immediately forces all outputs and state to reset values, including the pending buffer.
- Latency: redirect inputs affect pc_o at the next rising edge; no combinational path from inputs to pc_o.

Decomposition:
- Shared package riscv_pkg holds:
  - state enum pcs_state_t {BOOT, RUN, HOLD, BUBBLE}
  - constants XLEN_DEFAULT, RESET_PC_DEFAULT, TRAP_VEC_DEFAULT
- One sub-module, pc_src_mux: purely combinational priority selector.
  - Inputs: the trap/jump/branch requests and targets, pc_o + PC_STEP.
  - Outputs: next-PC, redirect flag, misaligned flag.
  - It replaces the old 2:1 mux.
- The sequencer owns the PC register, FSM and pending buffer.

Test Plan:
- Reset: rst_n low, then high; free-run 4 cycles → pc_o 0,0,4,8,12; pc_valid_o 0,0,1,1,1.
- Branch AND: branch_i=1, zero_i=0, target 0x40 at pc 0x8 → pc_o=0xC. Then zero_i=1 → pc_o=0x40, redirect_o pulse, one bubble cycle, then 0x44 valid.
- Stall buffering: stall_i high at pc 0x10, jump_i to 0x80 during stall, then branch to 0x90 → pend_o=1, pc_o holds 0x10. Release stall → pc_o=0x90, redirect_o pulse.
- Trap priority: trap_i, jump_i and a taken branch all in the same cycle with stall_i=1 → pc_o=0x100 next edge, pend_o=0.
- Misaligned: jump_target_i=0x42 → pc_o=0x100, misaligned_o=1 for one cycle.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC, run → pc_o wraps to 0x0. Assert rst_n mid-HOLD → all outputs reset immediately, without waiting for a clock edge.
